// File: rtl/gpio_board_bridge.sv
// Board-side GPIO-A bridge: debounced switches with sticky change flags on the
// read word, and LEDs driven static / blink / PWM from the write word.
module gpio_board_sw_lane #(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic io_mainClk,
  input  logic io_asyncReset,
  input  logic sw_i,
  input  logic clr_i,
  output logic stable_o,
  output logic flag_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          stable_q, stable_d;
  logic          flag_q, flag_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mism, fire;

  always_comb begin
    mism     = sync_q[1] ^ stable_q;
    fire     = mism && (cnt_q == CNT_MAX);
    cnt_d    = (!mism || fire) ? '0 : cnt_q + 1'b1;
    stable_d = fire ? sync_q[1] : stable_q;
    // a toggle in the same cycle as a clear keeps the flag
    flag_d   = fire | (flag_q & ~clr_i);
  end

  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      flag_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], sw_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      flag_q   <= flag_d;
    end
  end

  assign stable_o = stable_q;
  assign flag_o   = flag_q;
endmodule

module gpio_board_bridge #(
  parameter int NUM_SW          = 4,
  parameter int NUM_LED         = 5,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int BLINK_BITS      = 24
) (
  input  logic               io_mainClk,
  input  logic               io_asyncReset,
  input  logic [NUM_SW-1:0]  sw,
  output logic [NUM_LED-1:0] io_led,
  output logic [31:0]        io_gpioA_read,
  input  logic [31:0]        io_gpioA_write,
  input  logic [31:0]        io_gpioA_writeEnable
);
  logic [31:0]           ctl;
  logic [1:0]            mode;
  logic [7:0]            duty;
  logic                  ctl31_q, clr_q, clr_d;
  logic [NUM_SW-1:0]     stable, flag;
  logic [7:0]            stable8, flag8;
  logic [31:0]           read_q, read_d;
  logic [BLINK_BITS-1:0] blink_q;
  logic [7:0]            pwm_q;
  logic [NUM_LED-1:0]    led_q, led_d, on;
  logic                  unused_ctl;

  assign ctl        = io_gpioA_write & io_gpioA_writeEnable;
  assign mode       = ctl[9:8];
  assign duty       = ctl[23:16];
  assign clr_d      = ctl[31] & ~ctl31_q;
  assign unused_ctl = ^ctl;

  for (genvar g = 0; g < NUM_SW; g++) begin : g_lane
    gpio_board_sw_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .io_mainClk   (io_mainClk),
      .io_asyncReset(io_asyncReset),
      .sw_i         (sw[g]),
      .clr_i        (clr_q),
      .stable_o     (stable[g]),
      .flag_o       (flag[g])
    );
  end

  always_comb begin
    stable8               = '0;
    flag8                 = '0;
    stable8[NUM_SW-1:0]   = stable;
    flag8[NUM_SW-1:0]     = flag;
    read_d                = {15'b0, |flag, flag8, stable8};
  end

  // counters are compared at their pre-edge value, so LEDs track ctl with one register
  always_comb begin
    case (mode)
      2'b01:   on = {NUM_LED{blink_q[BLINK_BITS-1]}};
      2'b10:   on = {NUM_LED{pwm_q < duty}};
      default: on = '1;
    endcase
    led_d = ctl[NUM_LED-1:0] & on;
  end

  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      ctl31_q <= 1'b0;
      clr_q   <= 1'b0;
      read_q  <= '0;
      blink_q <= '0;
      pwm_q   <= '0;
      led_q   <= '0;
    end else begin
      ctl31_q <= ctl[31];
      clr_q   <= clr_d;
      read_q  <= read_d;
      blink_q <= blink_q + 1'b1;
      pwm_q   <= pwm_q + 1'b1;
      led_q   <= led_d;
    end
  end

  assign io_led        = led_q;
  assign io_gpioA_read = read_q;
endmodule

// File: tb/tb_gpio_board_bridge.sv
// Directed bench for gpio_board_bridge with short debounce and blink periods.
module tb_gpio_board_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  sw  = '0;
  logic [4:0]  led;
  logic [31:0] rd;
  logic [31:0] wr  = '0;
  logic [31:0] we  = '0;
  int          nvec = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  gpio_board_bridge #(
    .NUM_SW(4), .NUM_LED(5), .DEBOUNCE_CYCLES(4), .BLINK_BITS(4)
  ) dut (
    .io_mainClk          (clk),
    .io_asyncReset       (rst),
    .sw                  (sw),
    .io_led              (led),
    .io_gpioA_read       (rd),
    .io_gpioA_write      (wr),
    .io_gpioA_writeEnable(we)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pwm_run(input logic [7:0] duty, input string tag, input int exp_hi);
    int hi[5];
    @(negedge clk);
    wr = {8'h00, duty, 8'h02, 8'h1F};
    we = '1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) hi[i] = 0;
    repeat (256) begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) hi[i] += int'(led[i]);
    end
    for (int i = 0; i < 5; i++) chk($sformatf("%s_led%0d", tag, i), 32'(hi[i]), 32'(exp_hi));
  endtask

  task automatic blink_run();
    int          t;
    logic        p;
    logic [16:0] bits;
    logic [3:0]  others;
    @(negedge clk);
    wr = 32'h0000_0101;
    we = '1;
    repeat (2) @(negedge clk);
    t = 0;
    p = led[0];
    @(negedge clk);
    while (!(led[0] && !p) && t < 40) begin
      p = led[0];
      @(negedge clk);
      t++;
    end
    chk("blink_sync", {31'b0, t < 40}, 32'h1);
    bits   = '0;
    others = '0;
    for (int i = 0; i < 17; i++) begin
      bits[i] = led[0];
      others  = others | led[4:1];
      @(negedge clk);
    end
    chk("blink_pattern", {15'b0, bits}, 32'h0001_00FF);
    chk("blink_others", {28'b0, others}, 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_led", {27'b0, led}, 32'h0);
    chk("rst_read", rd, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // writeEnable masks the LED enables
    wr = 32'h1F;
    we = 32'h05;
    cyc(1);
    chk("mask_led", {27'b0, led}, 32'h05);

    // debounce: read updates exactly after edge k+6
    @(negedge clk);
    sw[0] = 1'b1;
    @(posedge clk);
    cyc(5);
    chk("db_k5", rd, 32'h0);
    cyc(1);
    chk("db_k6", rd, 32'h0001_0101);

    // 3-cycle glitch on sw[1] is rejected
    @(negedge clk);
    sw[1] = 1'b1;
    repeat (3) @(negedge clk);
    sw[1] = 1'b0;
    cyc(20);
    chk("glitch", rd, 32'h0001_0101);

    // rising bit 31 at edge n clears flags at n+1, visible after n+2
    @(negedge clk);
    wr = 32'h8000_0000;
    we = '1;
    @(posedge clk);
    cyc(1);
    chk("clr_n1", rd, 32'h0001_0101);
    cyc(1);
    chk("clr_n2", rd, 32'h0000_0001);
    @(negedge clk);
    wr = 32'h0;
    cyc(3);

    // toggle landing on the clear edge keeps its flag; holding bit 31 does not re-clear
    @(negedge clk);
    sw[0] = 1'b0;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    wr = 32'h8000_0000;
    @(posedge clk);
    cyc(1);
    chk("coin_k5", rd, 32'h0000_0001);
    cyc(1);
    chk("coin_k6", rd, 32'h0001_0100);
    cyc(4);
    chk("hold_noreclr", rd, 32'h0001_0100);
    @(negedge clk);
    wr = 32'h0;

    pwm_run(8'd64, "pwm64", 64);
    pwm_run(8'd0, "pwm0", 0);
    pwm_run(8'd255, "pwm255", 255);
    blink_run();

    // async reset mid-cycle with LEDs lit and flags set; sw[2] held through it
    @(negedge clk);
    wr    = 32'h1F;
    we    = '1;
    sw[2] = 1'b1;
    cyc(1);
    chk("pre_rst_led", {27'b0, led}, 32'h1F);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_led", {27'b0, led}, 32'h0);
    chk("midrst_read", rd, 32'h0);
    wr = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    cyc(5);
    chk("held_e5", rd, 32'h0);
    cyc(1);
    chk("held_e6", rd, 32'h0001_0404);
    chk("held_led", {27'b0, led}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
